// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD
   } ifu_state_e;

   localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;
   localparam logic [31:0] BUBBLE_INSTR     = 32'h0;

   localparam int unsigned STALL_PC = 0;
   localparam int unsigned STALL_IF = 1;

   function automatic logic [63:0] pc_inc(input logic [63:0] pc);
      return pc + 64'd4;
   endfunction

endpackage

// File: rtl/ifu_if.sv
// Instruction-bus request/response bundle between the fetch unit and memory.
interface ifu_if;

   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;

   modport master (
      output ireq_valid,
      output ireq_addr,
      input  iresp_data_ok,
      input  iresp_data
   );

   modport slave (
      input  ireq_valid,
      input  ireq_addr,
      output iresp_data_ok,
      output iresp_data
   );

endinterface

// File: rtl/ifu_pc_reg.sv
// Program counter with next-PC select: reset, redirect, sequential +4 (64-bit wrap) or hold.
module ifu_pc_reg
   import ifu_pkg::*;
#(
   parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_i,
   input  logic [63:0] target_i,
   input  logic        advance_i,
   output logic [63:0] pc_o
);

   logic [63:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = target_i;
      end else if (advance_i) begin
         pc_d = pc_inc(pc_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding bus request, hold buffer and IF/ID register.
// Optional IFU_MISALIGN_CHECK_EN suppresses requests from a misaligned PC and pulses ifu_misalign_o.
module ifu
   import ifu_pkg::*;
#(
   parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        branch_flag_i,
   input  logic [63:0] branch_target_i,
   ifu_if.master       ibus,
   output logic [31:0] instr,
   output logic [63:0] instaddr,
   output logic        branch_slot_end_o
`ifdef IFU_MISALIGN_CHECK_EN
   ,
   output logic        ifu_misalign_o
`endif
);

   ifu_state_e  state_q, state_d;
   logic [63:0] pc;
   logic        pc_adv;
   logic        stale_q, stale_d;
   logic        redir_q, redir_d;
   logic        inflight_q;
   logic [63:0] req_addr_q;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [63:0] hold_addr_q, hold_addr_d;
   logic        hold_bse_q, hold_bse_d;
   logic [31:0] instr_q, instr_d;
   logic [63:0] instaddr_q, instaddr_d;
   logic        bse_q, bse_d;
   logic        misalign;
   logic        unused_stall;

   assign unused_stall = ^stall[5:2];

`ifdef IFU_MISALIGN_CHECK_EN
   logic misal_q, misal_d;
   logic misal_rep_q, misal_rep_d;
   assign misalign = (pc[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   ifu_pc_reg #(
      .RESET_PC(RESET_PC)
   ) u_pc_reg (
      .clk       (clk),
      .rst       (rst),
      .redirect_i(branch_flag_i),
      .target_i  (branch_target_i),
      .advance_i (pc_adv),
      .pc_o      (pc)
   );

   always_comb begin
      state_d      = state_q;
      stale_d      = stale_q;
      redir_d      = redir_q;
      pc_adv       = 1'b0;
      hold_instr_d = hold_instr_q;
      hold_addr_d  = hold_addr_q;
      hold_bse_d   = hold_bse_q;
      instr_d      = instr_q;
      instaddr_d   = instaddr_q;
      bse_d        = bse_q;
      // IF/ID defaults to a bubble whenever it is not frozen; word loads override below.
      if (!stall[STALL_IF]) begin
         instr_d = BUBBLE_INSTR;
         bse_d   = 1'b0;
      end
      ibus.ireq_valid = 1'b0;
      // An outstanding request keeps its original address even after a redirect moves the PC.
      ibus.ireq_addr  = inflight_q ? req_addr_q : pc;
`ifdef IFU_MISALIGN_CHECK_EN
      misal_d     = 1'b0;
      misal_rep_d = misal_rep_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (!stall[STALL_PC]) state_d = S_REQ;
         end
         S_REQ: begin
            ibus.ireq_valid = inflight_q || (!stall[STALL_PC] && !misalign);
            if (ibus.ireq_valid && ibus.iresp_data_ok) begin
               if (stale_q) begin
                  stale_d = 1'b0;
               end else if (!branch_flag_i) begin
                  pc_adv  = 1'b1;
                  redir_d = 1'b0;
                  if (stall[STALL_IF]) begin
                     hold_instr_d = ibus.iresp_data;
                     hold_addr_d  = pc;
                     hold_bse_d   = redir_q;
                     state_d      = S_HOLD;
                  end else begin
                     instr_d    = ibus.iresp_data;
                     instaddr_d = pc;
                     bse_d      = redir_q;
                  end
               end
            end
`ifdef IFU_MISALIGN_CHECK_EN
            if (!inflight_q && misalign && !stall[STALL_IF] && !branch_flag_i && !misal_rep_q) begin
               instaddr_d  = pc;
               misal_d     = 1'b1;
               misal_rep_d = 1'b1;
            end
`endif
         end
         S_HOLD: begin
            if (!stall[STALL_IF] && !branch_flag_i) begin
               instr_d    = hold_instr_q;
               instaddr_d = hold_addr_q;
               bse_d      = hold_bse_q;
               state_d    = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (branch_flag_i) begin
         redir_d = 1'b1;
         stale_d = ibus.ireq_valid && !ibus.iresp_data_ok;
         if (state_q == S_HOLD) state_d = S_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
         misal_rep_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         stale_q      <= 1'b0;
         redir_q      <= 1'b0;
         inflight_q   <= 1'b0;
         req_addr_q   <= RESET_PC;
         hold_instr_q <= BUBBLE_INSTR;
         hold_addr_q  <= '0;
         hold_bse_q   <= 1'b0;
         instr_q      <= BUBBLE_INSTR;
         instaddr_q   <= '0;
         bse_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         stale_q      <= stale_d;
         redir_q      <= redir_d;
         inflight_q   <= ibus.ireq_valid && !ibus.iresp_data_ok;
         req_addr_q   <= ibus.ireq_addr;
         hold_instr_q <= hold_instr_d;
         hold_addr_q  <= hold_addr_d;
         hold_bse_q   <= hold_bse_d;
         instr_q      <= instr_d;
         instaddr_q   <= instaddr_d;
         bse_q        <= bse_d;
      end
   end

`ifdef IFU_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misal_q     <= 1'b0;
         misal_rep_q <= 1'b0;
      end else begin
         misal_q     <= misal_d;
         misal_rep_q <= misal_rep_d;
      end
   end

   assign ifu_misalign_o = misal_q;
`endif

   assign instr             = instr_q;
   assign instaddr          = instaddr_q;
   assign branch_slot_end_o = bse_q;

endmodule

// File: tb/tb_ifu.sv
// Directed plus randomized bench for ifu: an in-bench bus responder and a program-order fetch model.
module tb_ifu;
   import ifu_pkg::*;

   localparam logic [63:0] RPC = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic        branch_flag_i = 1'b0;
   logic [63:0] branch_target_i = '0;
   logic [31:0] instr;
   logic [63:0] instaddr;
   logic        branch_slot_end_o;
`ifdef IFU_MISALIGN_CHECK_EN
   logic        ifu_misalign_o;
`endif

   ifu_if bus ();

   ifu #(
      .RESET_PC(RPC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .branch_flag_i    (branch_flag_i),
      .branch_target_i  (branch_target_i),
      .ibus             (bus),
      .instr            (instr),
      .instaddr         (instaddr),
      .branch_slot_end_o(branch_slot_end_o)
`ifdef IFU_MISALIGN_CHECK_EN
      ,
      .ifu_misalign_o   (ifu_misalign_o)
`endif
   );

   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;

   // bus responder state
   logic        pend;
   logic [63:0] pend_addr;
   int          wait_left;
   int          force_wait;
   int unsigned lat_max;
   logic        last_valid, last_ok;
   logic [63:0] last_addr;

   // program-order model
   logic [63:0] exp_pc;
   logic        exp_bse;
   logic [31:0] prev_instr;
   logic [63:0] prev_instaddr;
   int unsigned delivered;

   function automatic logic [31:0] word(input logic [63:0] a);
      logic [29:0] hi;
      hi = a[31:2] ^ a[61:32];
      return {hi, 2'b11};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_eval();
      last_valid = bus.ireq_valid;
      last_addr  = bus.ireq_addr;
      bus.iresp_data_ok = 1'b0;
      bus.iresp_data    = $urandom();
      if (pend) begin
         chk("req_hold_valid", bus.ireq_valid, 1);
         chk("req_hold_addr", bus.ireq_addr, pend_addr);
      end else if (bus.ireq_valid) begin
         chk("req_issue_gate", stall[STALL_PC], 0);
         pend      = 1'b1;
         pend_addr = bus.ireq_addr;
         if (force_wait >= 0) begin
            wait_left  = force_wait;
            force_wait = -1;
         end else begin
            wait_left = int'($urandom_range(lat_max, 0));
         end
      end
      if (pend && bus.ireq_valid) begin
         if (wait_left == 0) begin
            bus.iresp_data_ok = 1'b1;
            bus.iresp_data    = word(pend_addr);
            pend              = 1'b0;
         end else begin
            wait_left--;
         end
      end
      last_ok = bus.iresp_data_ok;
   endtask

   task automatic observe(input logic st1, input logic br, input logic [63:0] tgt);
      logic [63:0] exp_ia;
      if (st1) begin
         chk("ifid_frozen_instr", instr, prev_instr);
         chk("ifid_frozen_addr", instaddr, prev_instaddr);
      end else begin
         if (br) chk("redir_bubble", instr, 0);
         if (instr === BUBBLE_INSTR) begin
            exp_ia = prev_instaddr;
`ifdef IFU_MISALIGN_CHECK_EN
            if (ifu_misalign_o) exp_ia = exp_pc;
`endif
            chk("bubble_addr", instaddr, exp_ia);
            chk("bubble_bse", branch_slot_end_o, 0);
         end else if (!br) begin
            chk("seq_instr", instr, word(exp_pc));
            chk("seq_addr", instaddr, exp_pc);
            chk("seq_bse", branch_slot_end_o, exp_bse);
            exp_pc  = exp_pc + 64'd4;
            exp_bse = 1'b0;
            delivered++;
         end
      end
      if (br) begin
         exp_pc  = tgt;
         exp_bse = 1'b1;
      end
      prev_instr    = instr;
      prev_instaddr = instaddr;
   endtask

   // Called at a negedge: drive inputs, answer the bus, cross one posedge, observe at the next negedge.
   task automatic step(input logic [5:0] st, input logic br, input logic [63:0] tgt);
      stall           = st;
      branch_flag_i   = br;
      branch_target_i = tgt;
      #1;
      bus_eval();
      @(negedge clk);
      observe(st[STALL_IF], br, tgt);
   endtask

   task automatic model_reset();
      pend          = 1'b0;
      force_wait    = -1;
      exp_pc        = RPC;
      exp_bse       = 1'b0;
      prev_instr    = '0;
      prev_instaddr = '0;
   endtask

   initial begin
      logic [5:0]  st;
      logic        br;
      logic [63:0] tgt;
      logic [63:0] hold_addr;

      bus.iresp_data_ok = 1'b0;
      bus.iresp_data    = '0;
      lat_max   = 0;
      delivered = 0;
      wait_left = 0;
      model_reset();

      #1 rst = 1'b0;
      #1;
      chk("rst_valid", bus.ireq_valid, 0);
      chk("rst_addr", bus.ireq_addr, RPC);
      chk("rst_instr", instr, 0);
      chk("rst_instaddr", instaddr, 0);
      chk("rst_bse", branch_slot_end_o, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // zero-wait back-to-back fetch
      step('0, 0, '0);
      chk("idle_noreq", last_valid, 0);
      step('0, 0, '0);
      chk("zw_req0", last_addr, RPC);
      chk("zw_instr0", instr, word(RPC));
      step('0, 0, '0);
      chk("zw_req1", last_addr, RPC + 64'h4);
      chk("zw_instr1", instr, word(RPC + 64'h4));
      step('0, 0, '0);
      chk("zw_req2", last_addr, RPC + 64'h8);
      chk("zw_bse", branch_slot_end_o, 0);

      // three wait cycles on the bus
      force_wait = 3;
      repeat (3) begin
         step('0, 0, '0);
         chk("wait_valid", last_valid, 1);
         chk("wait_addr", last_addr, RPC + 64'hC);
         chk("wait_instr", instr, 0);
      end
      step('0, 0, '0);
      chk("wait_done", instr, word(RPC + 64'hC));

      // redirect while a request is in flight
      force_wait = 2;
      step('0, 0, '0);
      step('0, 1, RPC + 64'h100);
      step('0, 0, '0);
      chk("stale_addr", last_addr, RPC + 64'h10);
      chk("stale_drop", instr, 0);
      step('0, 0, '0);
      chk("redir_req", last_addr, RPC + 64'h100);
      chk("redir_instr", instr, word(RPC + 64'h100));
      chk("redir_bse", branch_slot_end_o, 1);
      step('0, 0, '0);
      chk("redir_next_instr", instr, word(RPC + 64'h104));
      chk("redir_next_bse", branch_slot_end_o, 0);

      // stall[1] for four cycles while a word returns
      step(6'b000010, 0, '0);
      hold_addr = last_addr;
      chk("hold_capture_ok", last_ok, 1);
      repeat (3) begin
         step(6'b000010, 0, '0);
         chk("hold_noreq", last_valid, 0);
      end
      step('0, 0, '0);
      chk("hold_noreq_rel", last_valid, 0);
      chk("hold_emit", instr, word(hold_addr));
      chk("hold_emit_addr", instaddr, hold_addr);
      step('0, 0, '0);
      chk("post_hold_req", last_addr, hold_addr + 64'h4);

      // redirect in HOLD on the cycle stall[1] falls
      step(6'b000010, 0, '0);
      step(6'b000010, 0, '0);
      step('0, 1, RPC + 64'h200);
      chk("hold_redir_bubble", instr, 0);
      step('0, 0, '0);
      chk("hold_redir_req", last_addr, RPC + 64'h200);
      chk("hold_redir_instr", instr, word(RPC + 64'h200));
      chk("hold_redir_bse", branch_slot_end_o, 1);

      // redirect with same-cycle response, then PC wrap
      step('0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("simul_drop", instr, 0);
      step('0, 0, '0);
      chk("wrap_req0", last_addr, 64'hFFFF_FFFF_FFFF_FFF8);
      step('0, 0, '0);
      chk("wrap_req1", last_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      step('0, 0, '0);
      chk("wrap_req2", last_addr, 64'h0);
      chk("wrap_instaddr", instaddr, 64'h0);
      step('0, 1, RPC + 64'h400);

`ifdef IFU_MISALIGN_CHECK_EN
      step('0, 1, RPC + 64'h102);
      step('0, 0, '0);
      chk("mis_noreq", last_valid, 0);
      chk("mis_pulse", ifu_misalign_o, 1);
      chk("mis_addr", instaddr, RPC + 64'h102);
      step('0, 0, '0);
      chk("mis_noreq2", last_valid, 0);
      chk("mis_pulse_end", ifu_misalign_o, 0);
      step('0, 1, RPC + 64'h300);
`endif

      // randomized traffic
      lat_max = 3;
      for (int i = 0; i < 400; i++) begin
         st    = '0;
         st[0] = ($urandom_range(7, 0) == 0);
         st[1] = ($urandom_range(4, 0) == 0);
         st[5:2] = 4'($urandom());
         br    = ($urandom_range(15, 0) == 0);
         tgt   = RPC + 64'($urandom_range(1023, 0)) * 64'd4;
         step(st, br, tgt);
      end
      lat_max = 0;
      repeat (12) step('0, 0, '0);
      chk("progress", (delivered >= 60) ? 1 : 0, 1);

      // reset in the middle of a request
      force_wait = 5;
      step('0, 0, '0);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid_valid", bus.ireq_valid, 0);
      chk("rst_mid_addr", bus.ireq_addr, RPC);
      chk("rst_mid_instr", instr, 0);
      chk("rst_mid_bse", branch_slot_end_o, 0);
      model_reset();
      bus.iresp_data_ok = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("idle_noreq2", bus.ireq_valid, 0);
      bus.iresp_data_ok = 1'b1;
      bus.iresp_data    = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.iresp_data_ok = 1'b0;
      chk("idle_ignore", instr, 0);
      step('0, 0, '0);
      chk("post_rst_req", last_addr, RPC);
      chk("post_rst_instr", instr, word(RPC));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
